// File: rtl/mem_pkg.sv
// Shared definitions for the memory access sequencer.
//   ADDR_W  : RAM byte address width
//   DATA_W  : RAM data width (one byte per access)
//   WIDE_W  : width of a 16-bit CPU access
//   state_t : sequencer FSM states
package mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int WIDE_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        GAP  = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/mem_sequencer.sv
// Memory access sequencer: the only master of the RAM block.
// It turns byte and 16-bit little-endian CPU loads/stores into
// byte-wide RAM cycles, holds each write long enough for the RAM
// write-pulse gate, and returns a one-cycle completion pulse.
//
// Ports
//   clk, nrst        : clock, asynchronous active-low reset
//   req_valid/ready  : request handshake (ready only in IDLE)
//   req_wr, req_wide : store/load select, 2-byte access select
//   req_addr         : byte address (second byte at addr+1, wraps)
//   req_wdata        : store data, [15:8] used only for wide stores
//   resp_valid       : one-cycle completion pulse, no backpressure
//   resp_rdata       : load data ({8'h00,byte} for narrow loads)
//   ram_addr/wr/din  : registered RAM controls
//   ram_dout         : RAM read data, sampled READ_LAT cycles after
//                      the address is presented
//   dbg_state_o      : current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so nothing
// is accepted while an access (including its RESP cycle) is in flight
// and request inputs are ignored until the sequencer is back in IDLE.
// resp_valid is a pulse; the requester must take it when it appears.
module mem_sequencer
    import mem_pkg::*;
#(
    parameter int unsigned WR_HOLD  = 3,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_wide,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDE_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WIDE_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output state_t            dbg_state_o
);

    localparam logic [3:0]        WR_LAST  = 4'(WR_HOLD - 1);
    localparam logic [3:0]        RD_LAST  = 4'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t              state_q,      state_d;
    logic                bi_q,         bi_d;
    logic [3:0]          cnt_q,        cnt_d;
    logic                wide_q,       wide_d;
    logic [DATA_W-1:0]   wdata_hi_q,   wdata_hi_d;
    logic [ADDR_W-1:0]   ram_addr_q,   ram_addr_d;
    logic                ram_wr_q,     ram_wr_d;
    logic [DATA_W-1:0]   ram_din_q,    ram_din_d;
    logic                resp_valid_q, resp_valid_d;
    logic [WIDE_W-1:0]   resp_rdata_q, resp_rdata_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            bi_q         <= 1'b0;
            cnt_q        <= '0;
            wide_q       <= 1'b0;
            wdata_hi_q   <= '0;
            ram_addr_q   <= '0;
            ram_wr_q     <= 1'b0;
            ram_din_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            bi_q         <= bi_d;
            cnt_q        <= cnt_d;
            wide_q       <= wide_d;
            wdata_hi_q   <= wdata_hi_d;
            ram_addr_q   <= ram_addr_d;
            ram_wr_q     <= ram_wr_d;
            ram_din_q    <= ram_din_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bi_d         = bi_q;
        cnt_d        = cnt_q;
        wide_d       = wide_q;
        wdata_hi_d   = wdata_hi_q;
        ram_addr_d   = ram_addr_q;
        ram_wr_d     = ram_wr_q;
        ram_din_d    = ram_din_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                ram_wr_d = 1'b0;
                // req_ready is high in IDLE, so req_valid alone means accept.
                if (req_valid) begin
                    ram_addr_d = req_addr;
                    bi_d       = 1'b0;
                    cnt_d      = '0;
                    wide_d     = req_wide;
                    wdata_hi_d = req_wdata[15:8];
                    if (req_wr) begin
                        ram_wr_d  = 1'b1;
                        ram_din_d = req_wdata[7:0];
                        state_d   = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end

            RD: begin
                if (cnt_q == RD_LAST) begin
                    // Byte 0 also clears the high half so a narrow load
                    // returns {8'h00, byte}.
                    if (bi_q) begin
                        resp_rdata_d[15:8] = ram_dout;
                    end else begin
                        resp_rdata_d = {8'h00, ram_dout};
                    end
                    if (wide_q && !bi_q) begin
                        bi_d       = 1'b1;
                        ram_addr_d = ram_addr_q + ADDR_ONE;
                        cnt_d      = '0;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            WR: begin
                if (cnt_q == WR_LAST) begin
                    ram_wr_d = 1'b0;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            GAP: begin
                // Address and data stayed put through this cycle so the
                // RAM sees a clean trailing edge on the write pulse.
                if (wide_q && !bi_q) begin
                    bi_d       = 1'b1;
                    ram_addr_d = ram_addr_q + ADDR_ONE;
                    ram_din_d  = wdata_hi_q;
                    ram_wr_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = WR;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr      = ram_wr_q;
    assign ram_din     = ram_din_q;
    assign dbg_state_o = state_q;

endmodule
